// File: rtl/ingress_buffer_pkg.sv
// Shared definitions for the ingress buffers and the switch scheduler that drains them.
// Word bits [1:0] carry the destination code the scheduler decodes.
package ingress_buffer_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    DEST_P2_ALT = 2'b00,
    DEST_P1     = 2'b01,
    DEST_P2     = 2'b10,
    DEST_P3     = 2'b11
  } dest_t;

  function automatic dest_t word_dest(input logic [DATA_W-1:0] word);
    return dest_t'(word[1:0]);
  endfunction

endpackage

// File: rtl/ingress_buffer_if.sv
// MAC-side valid/ready word handshake into an ingress buffer.
interface ingress_buffer_if;
  import ingress_buffer_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ingress_buffer_ram.sv
// Simple dual-port RAM, registered read port, read-before-write on address collision.
module ingress_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_word,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_word
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Read register: the non-blocking write above lands after this sample, giving old data
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_word <= '0;
    end else if (re) begin
      rd_word <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ingress_buffer.sv
// Per-port ingress buffer: accepts MAC words, stores nonzero ones, exposes the write
// pointer and a scheduler-addressed read port.
module ingress_buffer
  import ingress_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  ingress_buffer_if.slave   in_if,
  input  logic [ADDR_W-1:0] rd_add,
  input  logic              rden,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_add,
  output logic [ADDR_W-1:0] occupancy,
  output logic              full,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic fire;
  logic wr_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // One slot is always left empty so that full and empty stay distinguishable
  assign occupancy      = wr_add - rd_add;
  assign full           = (occupancy == {ADDR_W{1'b1}});
  assign in_if.in_ready = !full && !reset;
  assign fire           = in_if.in_valid && in_if.in_ready;
  assign wr_en          = fire && (in_if.in_data != '0);

  // Accept stage: zero words mark empty slots downstream, so they are counted but never stored
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_add   <= '0;
      acc_cnt  <= '0;
      drop_cnt <= '0;
    end else if (fire) begin
      if (wr_en) begin
        wr_add  <= wr_add + ADDR_W'(1);
        acc_cnt <= sat_inc(acc_cnt);
      end else begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  ingress_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_en),
    .wr_addr (wr_add),
    .wr_word (in_if.in_data),
    .re      (rden),
    .rd_addr (rd_add),
    .rd_word (rd_data)
  );

endmodule
